// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win; the clear engine and then a small CPU write
// FIFO use the remaining slots. All MEM_* outputs are registered.
module vram_arbiter #(
  parameter int RES_W       = 200,
  parameter int RES_H       = 150,
  parameter int COLOR_DEPTH = 3,
  parameter int ADDR_W      = 15,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   PIXEL_CLOCK,
  input  logic                   RESET,
  input  logic [10:0]            PX,
  input  logic [9:0]             PY,
  input  logic                   ON_SCREEN,
  output logic [COLOR_DEPTH-1:0] SCAN_DATA,
  input  logic                   WR_REQ,
  input  logic [7:0]             WR_X,
  input  logic [7:0]             WR_Y,
  input  logic [COLOR_DEPTH-1:0] WR_COLOR,
  output logic                   WR_READY,
  output logic                   WR_DROP,
  input  logic                   CLR_START,
  input  logic [COLOR_DEPTH-1:0] CLR_COLOR,
  output logic                   CLR_BUSY,
  output logic [ADDR_W-1:0]      MEM_ADDR,
  output logic                   MEM_WE,
  output logic [COLOR_DEPTH-1:0] MEM_WDATA,
  input  logic [COLOR_DEPTH-1:0] MEM_RDATA
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RES_W * RES_H - 1);
  localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(RES_W);
  localparam logic [7:0]        X_LIM     = 8'(RES_W);
  localparam logic [7:0]        Y_LIM     = 8'(RES_H);
  localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [0:0]        ST_IDLE   = 1'b0;
  localparam logic [0:0]        ST_CLEAR  = 1'b1;

  // Constant-pitch multiply; reduces to (y<<7)+(y<<6)+(y<<3) for a 200-pixel row.
  function automatic logic [ADDR_W-1:0] f_pix_addr(input logic [7:0] x, input logic [7:0] y);
    return ADDR_W'(y) * ROW_PITCH + ADDR_W'(x);
  endfunction

  logic [0:0]             r_state;
  logic [ADDR_W-1:0]      r_clr_cnt;
  logic [COLOR_DEPTH-1:0] r_clr_color;
  logic [ADDR_W-1:0]      r_fifo_addr  [FIFO_DEPTH];
  logic [COLOR_DEPTH-1:0] r_fifo_color [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W:0]         r_count;
  logic                   r_ready;
  logic                   r_drop;
  logic                   r_rd_p1;
  logic                   r_rd_p2;
  logic [COLOR_DEPTH-1:0] r_scan_data;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic                   r_mem_we;
  logic [COLOR_DEPTH-1:0] r_mem_wdata;

  logic              w_scan;
  logic [ADDR_W-1:0] w_scan_addr;
  logic              w_busy;
  logic              w_grant_clr;
  logic              w_grant_fifo;
  logic              w_accept;
  logic              w_in_range;
  logic              w_push;
  logic [PTR_W:0]    w_count_next;
  logic              w_unused_bits;

  assign w_unused_bits = ^{PX[10], PY[1:0]};

  assign w_scan       = ON_SCREEN && (PX[1:0] == 2'b00);
  assign w_scan_addr  = f_pix_addr(PX[9:2], PY[9:2]);
  assign w_busy       = (r_state == ST_CLEAR);
  assign w_grant_clr  = !w_scan && w_busy;
  assign w_grant_fifo = !w_scan && !w_busy && (r_count != '0);
  assign w_accept     = WR_REQ && r_ready;
  assign w_in_range   = (WR_X < X_LIM) && (WR_Y < Y_LIM);
  assign w_push       = w_accept && w_in_range;
  assign w_count_next = r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_grant_fifo);

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= '0;
    end else if (r_state == ST_IDLE) begin
      if (CLR_START) begin
        r_state     <= ST_CLEAR;
        r_clr_cnt   <= '0;
        r_clr_color <= CLR_COLOR;
      end
    end else if (w_grant_clr) begin
      if (r_clr_cnt == LAST_ADDR) begin
        r_state   <= ST_IDLE;
        r_clr_cnt <= '0;
      end else begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by r_count.
  always_ff @(posedge PIXEL_CLOCK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr]  <= f_pix_addr(WR_X, WR_Y);
      r_fifo_color[r_wr_ptr] <= WR_COLOR;
    end
  end

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_grant_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_ready <= (w_count_next != FULL_CNT);
      r_drop  <= w_accept && !w_in_range;
    end
  end

  always_ff @(posedge PIXEL_CLOCK or posedge RESET) begin
    if (RESET) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rd_p1     <= 1'b0;
      r_rd_p2     <= 1'b0;
      r_scan_data <= '0;
    end else begin
      if (w_scan) begin
        r_mem_addr <= w_scan_addr;
        r_mem_we   <= 1'b0;
      end else if (w_grant_clr) begin
        r_mem_addr  <= r_clr_cnt;
        r_mem_we    <= 1'b1;
        r_mem_wdata <= r_clr_color;
      end else if (w_grant_fifo) begin
        r_mem_addr  <= r_fifo_addr[r_rd_ptr];
        r_mem_we    <= 1'b1;
        r_mem_wdata <= r_fifo_color[r_rd_ptr];
      end else begin
        r_mem_we <= 1'b0;
      end
      // Read data arrives two cycles after the slot decision.
      r_rd_p1 <= w_scan;
      r_rd_p2 <= r_rd_p1;
      if (r_rd_p2) r_scan_data <= MEM_RDATA;
    end
  end

  assign SCAN_DATA = r_scan_data;
  assign WR_READY  = r_ready;
  assign WR_DROP   = r_drop;
  assign CLR_BUSY  = w_busy;
  assign MEM_ADDR  = r_mem_addr;
  assign MEM_WE    = r_mem_we;
  assign MEM_WDATA = r_mem_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a VRAM model with 1-cycle read latency and a write log
// captured on the falling edge.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        RESET;
  logic [10:0] PX;
  logic [9:0]  PY;
  logic        ON_SCREEN;
  logic [2:0]  SCAN_DATA;
  logic        WR_REQ;
  logic [7:0]  WR_X;
  logic [7:0]  WR_Y;
  logic [2:0]  WR_COLOR;
  logic        WR_READY;
  logic        WR_DROP;
  logic        CLR_START;
  logic [2:0]  CLR_COLOR;
  logic        CLR_BUSY;
  logic [14:0] MEM_ADDR;
  logic        MEM_WE;
  logic [2:0]  MEM_WDATA;
  logic [2:0]  MEM_RDATA;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]  mem [32768];
  logic        preload_req;
  logic [14:0] log_addr [$];
  logic [2:0]  log_data [$];
  int          n_conflict = 0;
  logic        prev_scan  = 1'b0;

  logic [7:0] tx [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd199};
  logic [7:0] ty [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd149};
  logic [2:0] tc [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};

  vram_arbiter dut (
    .PIXEL_CLOCK(clk),
    .RESET      (RESET),
    .PX         (PX),
    .PY         (PY),
    .ON_SCREEN  (ON_SCREEN),
    .SCAN_DATA  (SCAN_DATA),
    .WR_REQ     (WR_REQ),
    .WR_X       (WR_X),
    .WR_Y       (WR_Y),
    .WR_COLOR   (WR_COLOR),
    .WR_READY   (WR_READY),
    .WR_DROP    (WR_DROP),
    .CLR_START  (CLR_START),
    .CLR_COLOR  (CLR_COLOR),
    .CLR_BUSY   (CLR_BUSY),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_WE     (MEM_WE),
    .MEM_WDATA  (MEM_WDATA),
    .MEM_RDATA  (MEM_RDATA)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] pat(input logic [14:0] a);
    return a[2:0] ^ a[5:3];
  endfunction

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 32768; i++) mem[i] <= pat(15'(i));
    end else if (MEM_WE) begin
      mem[MEM_ADDR] <= MEM_WDATA;
    end
    MEM_RDATA <= mem[MEM_ADDR];
  end

  // A write seen one cycle after a scan slot means the slot was stolen.
  always @(negedge clk) begin
    if (!RESET && MEM_WE) begin
      log_addr.push_back(MEM_ADDR);
      log_data.push_back(MEM_WDATA);
      if (prev_scan) n_conflict <= n_conflict + 1;
    end
    prev_scan <= !RESET && ON_SCREEN && (PX[1:0] == 2'b00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_seq(input int base, input logic [2:0] col, output int errs);
    errs = 0;
    if (log_addr.size() < base + 30000) errs = 1;
    for (int i = 0; i < 30000 && base + i < log_addr.size(); i++) begin
      if (log_addr[base + i] != 15'(i) || log_data[base + i] != col) errs++;
    end
  endtask

  int         base;
  int         cbase;
  int         errs;
  int         busy_cnt;
  int         k;
  logic       acc;
  logic       pend_chk;
  logic       v1, v2, v3, cur_v;
  logic [14:0] a1, a2, a3, cur_a;

  initial begin
    RESET = 1'b1; preload_req = 1'b1;
    PX = '0; PY = '0; ON_SCREEN = 1'b0;
    WR_REQ = 1'b0; WR_X = '0; WR_Y = '0; WR_COLOR = '0;
    CLR_START = 1'b0; CLR_COLOR = '0;
    step();
    preload_req = 1'b0;
    step();
    @(negedge clk);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_we", MEM_WE, 0);
    check("rst_wdata", MEM_WDATA, 0);
    check("rst_scan", SCAN_DATA, 0);
    check("rst_ready", WR_READY, 1);
    check("rst_drop", WR_DROP, 0);
    check("rst_busy", CLR_BUSY, 0);
    step();
    RESET = 1'b0;
    step();

    // CPU write to the last pixel, then an out-of-range drop.
    base = log_addr.size();
    WR_REQ = 1'b1; WR_X = 8'd199; WR_Y = 8'd149; WR_COLOR = 3'b101;
    step();
    WR_REQ = 1'b0;
    @(negedge clk);
    check("wr_early_we", MEM_WE, 0);
    step();
    @(negedge clk);
    check("wr_we", MEM_WE, 1);
    check("wr_addr", MEM_ADDR, 29999);
    check("wr_data", MEM_WDATA, 3'b101);
    step();
    WR_REQ = 1'b1; WR_X = 8'd200; WR_Y = 8'd0; WR_COLOR = 3'b011;
    step();
    WR_REQ = 1'b0;
    @(negedge clk);
    check("drop_pulse", WR_DROP, 1);
    step();
    @(negedge clk);
    check("drop_end", WR_DROP, 0);
    for (int i = 0; i < 3; i++) step();
    check("drop_no_write", log_addr.size() - base, 1);

    // Scan sweep across row 10 (PY=40).
    PY = 10'd40;
    v1 = 0; v2 = 0; v3 = 0; a1 = '0; a2 = '0; a3 = '0;
    for (int p = 0; p < 804; p++) begin
      if (p < 800) begin ON_SCREEN = 1'b1; PX = 11'(p); end
      else begin ON_SCREEN = 1'b0; PX = '0; end
      cur_v = (p < 800) && (p % 4 == 0);
      cur_a = 15'(2000 + p / 4);
      @(negedge clk);
      if (v1) begin
        check("scan_we", MEM_WE, 0);
        check("scan_addr", MEM_ADDR, a1);
      end
      if (v3) check("scan_data", SCAN_DATA, pat(a3));
      v3 = v2; a3 = a2; v2 = v1; a2 = a1; v1 = cur_v; a1 = cur_a;
      step();
    end
    for (int i = 0; i < 10; i++) begin PX = 11'(i * 4); step(); end
    @(negedge clk);
    check("scan_hold", SCAN_DATA, pat(15'd2199));
    step();

    // Off-screen clear with a second start and a CPU write mid-clear.
    ON_SCREEN = 1'b0;
    base = log_addr.size();
    CLR_START = 1'b1; CLR_COLOR = 3'b010;
    step();
    CLR_START = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (!CLR_BUSY) break;
      busy_cnt++;
      step();
      CLR_START = (c == 100);
      CLR_COLOR = (c == 100) ? 3'b111 : 3'b010;
      WR_REQ = (c == 200);
      WR_X = 8'd5; WR_Y = 8'd0; WR_COLOR = 3'b110;
    end
    CLR_START = 1'b0; WR_REQ = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("clr_busy_cycles", busy_cnt, 30000);
    check("clr_write_count", log_addr.size() - base, 30001);
    clr_seq(base, 3'b010, errs);
    check("clr_seq_errs", errs, 0);
    if (log_addr.size() >= base + 30001) begin
      check("clr_cpu_addr", log_addr[base + 30000], 5);
      check("clr_cpu_data", log_data[base + 30000], 3'b110);
    end else begin
      check("clr_cpu_present", log_addr.size() - base, 30001);
    end

    // On-screen clear blocking the FIFO; five back-to-back pushes.
    ON_SCREEN = 1'b1; PY = '0; PX = '0;
    base = log_addr.size(); cbase = n_conflict;
    CLR_START = 1'b1; CLR_COLOR = 3'b001;
    step();
    CLR_START = 1'b0;
    k = 0; pend_chk = 1'b0;
    for (int c = 1; c < 60000; c++) begin
      PX = 11'(c % 800);
      if (k < 5) begin
        WR_REQ = 1'b1; WR_X = tx[k]; WR_Y = ty[k]; WR_COLOR = tc[k];
      end else begin
        WR_REQ = 1'b0;
      end
      acc = WR_REQ && WR_READY;
      @(negedge clk);
      if (pend_chk) begin
        check("fifo_full_ready", WR_READY, 0);
        pend_chk = 1'b0;
      end
      step();
      if (acc) begin
        k++;
        if (k == 4) pend_chk = 1'b1;
      end
      if (k == 5 && !CLR_BUSY && log_addr.size() - base >= 30005) break;
    end
    WR_REQ = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("fifth_accepted", k, 5);
    check("full_write_count", log_addr.size() - base, 30005);
    clr_seq(base, 3'b001, errs);
    check("full_clr_seq_errs", errs, 0);
    for (int i = 0; i < 5; i++) begin
      if (log_addr.size() > base + 30000 + i) begin
        check("fifo_order_addr", log_addr[base + 30000 + i],
              32'(ty[i]) * 200 + 32'(tx[i]));
        check("fifo_order_data", log_data[base + 30000 + i], tc[i]);
      end else begin
        check("fifo_order_present", log_addr.size() - base, 30005);
      end
    end
    check("scan_conflicts", n_conflict - cbase, 0);

    // Asynchronous reset mid-clear with two FIFO entries pending.
    ON_SCREEN = 1'b0; PX = '0;
    CLR_START = 1'b1; CLR_COLOR = 3'b011;
    step();
    CLR_START = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WR_REQ = 1'b1; WR_X = 8'(10 + i); WR_Y = 8'd1; WR_COLOR = 3'b100;
      step();
    end
    WR_REQ = 1'b0;
    for (int i = 0; i < 10; i++) step();
    @(negedge clk);
    check("pre_rst_busy", CLR_BUSY, 1);
    check("pre_rst_we", MEM_WE, 1);
    step();
    #2;
    RESET = 1'b1;
    #1;
    check("arst_we", MEM_WE, 0);
    check("arst_addr", MEM_ADDR, 0);
    check("arst_wdata", MEM_WDATA, 0);
    check("arst_scan", SCAN_DATA, 0);
    check("arst_ready", WR_READY, 1);
    check("arst_drop", WR_DROP, 0);
    check("arst_busy", CLR_BUSY, 0);
    step();
    step();
    RESET = 1'b0;
    base = log_addr.size();
    for (int i = 0; i < 50; i++) step();
    check("post_rst_writes", log_addr.size() - base, 0);
    check("post_rst_busy", CLR_BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port VRAM arbiter and sequencer for the GPU framebuffer (200x150, 3-bit colour, 30000 words). It shares one memory port between three requesters:
- the scanout path, which reads one pixel per 4 pixel clocks while on screen;
- a 4-deep CPU pixel-write FIFO;
- a hardware clear engine that fills the whole frame with one colour.

Scanout always wins. The clear engine and CPU writes use the remaining slots.

## Interface
- RES_W, 200: frame width in pixels
- RES_H, 150: frame height in pixels
- COLOR_DEPTH, 3: bits per pixel
- ADDR_W, 15: VRAM address width
- FIFO_DEPTH, 4: CPU write FIFO entries (power of two)

Ports (one clock; reset is asynchronous and active-high):
- PIXEL_CLOCK  in  1  sole clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- PX  in  11  current beam column (0..799 on screen)
- PY  in  10  current beam row (0..599 on screen)
- ON_SCREEN  in  1  beam in visible area
- SCAN_DATA  out  COLOR_DEPTH  latest scanout pixel, held between updates
- WR_REQ  in  1  CPU pixel write request
- WR_X  in  8  write column
- WR_Y  in  8  write row
- WR_COLOR  in  COLOR_DEPTH  write colour
- WR_READY  out  1  FIFO not full
- WR_DROP  out  1  one-cycle pulse: accepted request was out of range and discarded
- CLR_START  in  1  start full-frame clear
- CLR_COLOR  in  COLOR_DEPTH  fill colour, sampled at start
- CLR_BUSY  out  1  clear in progress
- MEM_ADDR  out  ADDR_W  VRAM address, registered
- MEM_WE  out  1  VRAM write enable, registered
- MEM_WDATA  out  COLOR_DEPTH  VRAM write data, registered
- MEM_RDATA  in  COLOR_DEPTH  VRAM read data, valid 1 cycle after address

## Operation
- Address mapping: addr = y*200 + x = (y<<7)+(y<<6)+(y<<3)+x, computed at 15 bits with no truncation. Maximum address is 29999.
- Scan slot:
  - Occurs in any cycle with ON_SCREEN=1 and PX[1:0]=0.
  - Scan coordinates are x=PX[9:2], y=PY[9:2].
  - The slot issues a read (MEM_WE=0).
- Grant priority, evaluated each cycle: scan slot > clear engine (if CLR_BUSY) > FIFO head (if non-empty) > idle.
  - Idle means MEM_WE=0 and MEM_ADDR holds its previous value.
- While CLR_BUSY=1 the FIFO is not drained, so CPU writes issued during a clear land after it. The FIFO still accepts pushes until full.
- CPU write acceptance:
  - A request is accepted when WR_REQ=1 and WR_READY=1.
  - If WR_X>=200 or WR_Y>=150, the request is not enqueued and WR_DROP pulses on the next cycle.
  - Otherwise {address, colour} is pushed.
- FIFO:
  - Push and pop in the same cycle is legal; the count is unchanged.
  - A push when full cannot occur because WR_READY=0.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on CLR_START: latch CLR_COLOR, counter=0, CLR_BUSY=1.
  - In CLEAR, each granted clear slot writes counter/colour and increments the counter.
  - CLEAR -> IDLE after the write to address 29999 is issued.
  - CLR_START while in CLEAR is ignored.
- Reset values: MEM_ADDR=0, MEM_WE=0, MEM_WDATA=0, SCAN_DATA=0, WR_READY=1, WR_DROP=0, CLR_BUSY=0, FIFO empty, clear counter 0, FSM IDLE.
- Reset mid-clear or with FIFO entries pending aborts everything. VRAM contents are left as they are.

## Timing
- Grant decided in cycle n appears on MEM_* in cycle n+1 (registered).
- For a scan slot in cycle n: MEM_RDATA is valid in n+2 and SCAN_DATA updates at the edge ending n+2, visible in n+3. Fixed latency is 3 pixel clocks, which the video timing compensates for.
- SCAN_DATA changes only on scan reads. It is held off screen.
- WR_READY is registered. It deasserts the cycle after the FIFO fills and reasserts the cycle after a pop.
- Write bandwidth:
  - On screen, 3 of every 4 cycles are free for clear/FIFO.
  - Off screen, every cycle is free.
  - A full clear takes at least 30000 cycles.
- FIFO-to-VRAM latency: a push in cycle n can be granted in n+1 at the earliest and appears on MEM_* in n+2.

## Test plan
- Reset mid-operation: assert RESET asynchronously mid-clear with 2 FIFO entries pending. Required response: all outputs return to reset values immediately; after release, no further MEM_WE pulses occur.
- Scan only: ON_SCREEN=1, PX sweeps 0..799 at PY=40, preloaded memory model. Required response: a MEM_WE=0 read on every PX[1:0]=0 cycle with MEM_ADDR=10*200+PX[9:2]; SCAN_DATA matches the model 3 cycles later.
- CPU write: WR_X=199, WR_Y=149, colour 3'b101 while off screen. Required response: MEM_WE=1, MEM_ADDR=29999, MEM_WDATA=3'b101 two cycles after acceptance. Then WR_X=200: WR_DROP pulses once and no VRAM write occurs.
- FIFO full and contention: push 5 writes back-to-back while on screen with PX[1:0]=0 every 4th cycle. Required response:
  - WR_READY drops after the 4th push.
  - No write ever lands on a scan cycle.
  - All 4 writes appear in order.
  - The 5th write is accepted once WR_READY returns.
- Clear: CLR_START with colour 3'b010 off screen. Required response:
  - CLR_BUSY is high for 30000 cycles.
  - Addresses 0..29999 are each written exactly once with 3'b010.
  - A second CLR_START mid-clear is ignored.
  - A CPU write pushed mid-clear lands after address 29999.
